// File: rtl/seg_display_if.sv
// Bus between a scan-strobe/value source and the 7-segment display scanner.
interface seg_display_if #(
    parameter int DIGITS = 4
);
    logic                  tick;
    logic                  load;
    logic [4*DIGITS-1:0]   value;
    logic [DIGITS-1:0]     dp_in;
    logic                  lz_blank;
    logic [DIGITS-1:0]     an;
    logic [6:0]            seg;
    logic                  dp;
    logic                  frame_done;

    modport master (
        output tick, load, value, dp_in, lz_blank,
        input  an, seg, dp, frame_done
    );

    modport slave (
        input  tick, load, value, dp_in, lz_blank,
        output an, seg, dp, frame_done
    );
endinterface

// File: rtl/seg_display_scanner.sv
// Multiplexed 7-segment scanner: per-digit SHOW slots separated by blank gaps,
// frame-synchronous value commit and optional leading-zero blanking.
module seg_display_scanner #(
    parameter int DIGITS         = 4,
    parameter int BLANK_CYCLES   = 2,
    parameter bit AN_ACTIVE_LOW  = 1'b1,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input logic          clk,
    input logic          rst,
    seg_display_if.slave bus
);
    localparam int               IDX_W    = $clog2(DIGITS);
    localparam logic [0:0]       ST_BLANK = 1'b0;
    localparam logic [0:0]       ST_SHOW  = 1'b1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [8:0]       GAP_LEN  = 9'(BLANK_CYCLES);
    localparam logic [DIGITS-1:0] AN_OFF  = AN_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
    localparam logic [6:0]       SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic             DP_OFF   = SEG_ACTIVE_LOW ? 1'b1 : 1'b0;

    // Active-high {g,f,e,d,c,b,a} pattern for one hex nibble.
    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        case (nib)
            4'h0:    hex_decode = 7'h3F;
            4'h1:    hex_decode = 7'h06;
            4'h2:    hex_decode = 7'h5B;
            4'h3:    hex_decode = 7'h4F;
            4'h4:    hex_decode = 7'h66;
            4'h5:    hex_decode = 7'h6D;
            4'h6:    hex_decode = 7'h7D;
            4'h7:    hex_decode = 7'h07;
            4'h8:    hex_decode = 7'h7F;
            4'h9:    hex_decode = 7'h6F;
            4'hA:    hex_decode = 7'h77;
            4'hB:    hex_decode = 7'h7C;
            4'hC:    hex_decode = 7'h39;
            4'hD:    hex_decode = 7'h5E;
            4'hE:    hex_decode = 7'h79;
            4'hF:    hex_decode = 7'h71;
            default: hex_decode = 7'h00;
        endcase
    endfunction

    logic [0:0]          state_r, state_s;
    logic [IDX_W-1:0]    idx_r, idx_s;
    logic [7:0]          gap_r, gap_s;
    logic                wrap_s;
    logic [4*DIGITS-1:0] pend_val_r, pend_val_s, disp_val_r, disp_val_s;
    logic [DIGITS-1:0]   pend_dp_r, pend_dp_s, disp_dp_r, disp_dp_s;
    logic [DIGITS-1:0]   lz_mask_s;
    logic                zero_run_s;
    logic                lit_s;
    logic [3:0]          nib_s;
    logic [DIGITS-1:0]   an_act_s, an_s, an_r;
    logic [6:0]          seg_act_s, seg_s, seg_r;
    logic                dp_act_s, dp_s, dp_r;
    logic                frame_done_r;

    // Scan FSM: gap counting in BLANK, tick-driven digit advance in SHOW.
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        gap_s   = gap_r;
        wrap_s  = 1'b0;
        case (state_r)
            ST_BLANK: begin
                if (({1'b0, gap_r} + 9'd1) >= GAP_LEN) begin
                    state_s = ST_SHOW;
                    gap_s   = 8'd0;
                end else begin
                    gap_s = gap_r + 8'd1;
                end
            end
            ST_SHOW: begin
                if (bus.tick) begin
                    wrap_s  = (idx_r == IDX_LAST);
                    idx_s   = wrap_s ? {IDX_W{1'b0}} : idx_r + IDX_W'(1);
                    state_s = (GAP_LEN == 9'd0) ? ST_SHOW : ST_BLANK;
                    gap_s   = 8'd0;
                end else begin
                    state_s = ST_SHOW;
                end
            end
            default: begin
                state_s = ST_BLANK;
                idx_s   = {IDX_W{1'b0}};
                gap_s   = 8'd0;
            end
        endcase
    end

    // Pending capture and frame-wrap commit; a load on the wrap edge bypasses straight through.
    always_comb begin
        pend_val_s = bus.load ? bus.value : pend_val_r;
        pend_dp_s  = bus.load ? bus.dp_in : pend_dp_r;
        disp_val_s = wrap_s ? pend_val_s : disp_val_r;
        disp_dp_s  = wrap_s ? pend_dp_s : disp_dp_r;
    end

    // Digit k is a leading zero when every nibble from the top down to k is zero.
    always_comb begin
        zero_run_s = 1'b1;
        lz_mask_s  = {DIGITS{1'b0}};
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_run_s   = zero_run_s & (disp_val_s[4*k +: 4] == 4'h0);
            lz_mask_s[k] = zero_run_s & (k != 0);
        end
    end

    // Outputs derived from next-state so they change on the edge the FSM enters a state.
    always_comb begin
        nib_s = disp_val_s[{idx_s, 2'b00} +: 4];
        lit_s = (state_s == ST_SHOW) && !(bus.lz_blank && lz_mask_s[idx_s]);
        if (lit_s) begin
            an_act_s  = DIGITS'(1) << idx_s;
            seg_act_s = hex_decode(nib_s);
            dp_act_s  = disp_dp_s[idx_s];
        end else begin
            an_act_s  = {DIGITS{1'b0}};
            seg_act_s = 7'h00;
            dp_act_s  = 1'b0;
        end
        an_s  = AN_ACTIVE_LOW ? ~an_act_s : an_act_s;
        seg_s = SEG_ACTIVE_LOW ? ~seg_act_s : seg_act_s;
        dp_s  = SEG_ACTIVE_LOW ? ~dp_act_s : dp_act_s;
    end

    // State, data and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_BLANK;
            idx_r        <= {IDX_W{1'b0}};
            gap_r        <= 8'd0;
            pend_val_r   <= {(4*DIGITS){1'b0}};
            pend_dp_r    <= {DIGITS{1'b0}};
            disp_val_r   <= {(4*DIGITS){1'b0}};
            disp_dp_r    <= {DIGITS{1'b0}};
            an_r         <= AN_OFF;
            seg_r        <= SEG_OFF;
            dp_r         <= DP_OFF;
            frame_done_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            idx_r        <= idx_s;
            gap_r        <= gap_s;
            pend_val_r   <= pend_val_s;
            pend_dp_r    <= pend_dp_s;
            disp_val_r   <= disp_val_s;
            disp_dp_r    <= disp_dp_s;
            an_r         <= an_s;
            seg_r        <= seg_s;
            dp_r         <= dp_s;
            frame_done_r <= wrap_s;
        end
    end

    assign bus.an         = an_r;
    assign bus.seg        = seg_r;
    assign bus.dp         = dp_r;
    assign bus.frame_done = frame_done_r;
endmodule

// File: tb/tb_seg_display_scanner.sv
// Directed bench for seg_display_scanner: per-frame vector table plus hand sequences.
module tb_seg_display_scanner;
    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    seg_display_if #(.DIGITS(4)) bus ();
    seg_display_if #(.DIGITS(4)) bus0 ();

    seg_display_scanner #(.DIGITS(4), .BLANK_CYCLES(2), .AN_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1))
        u_dut (.clk(clk), .rst(rst), .bus(bus));

    seg_display_scanner #(.DIGITS(4), .BLANK_CYCLES(0), .AN_ACTIVE_LOW(1'b1), .SEG_ACTIVE_LOW(1'b1))
        u_dut0 (.clk(clk), .rst(rst), .bus(bus0));

    typedef struct packed {
        logic [15:0]     value;
        logic [3:0]      dp_in;
        logic            lz;
        logic [3:0][3:0] an;
        logic [3:0][6:0] seg;
        logic [3:0]      dp;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // From a SHOW slot: tick, two gap clocks, land in SHOW of the next digit.
    task automatic next_digit();
        bus.tick = 1'b1;
        step();
        bus.tick = 1'b0;
        step();
        step();
    endtask

    initial begin
        rst = 1'b1;
        bus.tick = 1'b0; bus.load = 1'b0; bus.value = 16'h0000; bus.dp_in = 4'b0000; bus.lz_blank = 1'b0;
        bus0.tick = 1'b0; bus0.load = 1'b0; bus0.value = 16'h0000; bus0.dp_in = 4'b0000; bus0.lz_blank = 1'b0;

        vecs[0] = '{16'h12AF, 4'b0000, 1'b0, {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                    {7'h79, 7'h24, 7'h08, 7'h0E}, 4'b1111};
        vecs[1] = '{16'h0050, 4'b0000, 1'b1, {4'b1111, 4'b1111, 4'b1101, 4'b1110},
                    {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'b1111};
        vecs[2] = '{16'h0000, 4'b0000, 1'b1, {4'b1111, 4'b1111, 4'b1111, 4'b1110},
                    {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111};
        vecs[3] = '{16'h0000, 4'b0000, 1'b0, {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                    {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111};
        vecs[4] = '{16'h3C7E, 4'b0101, 1'b0, {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                    {7'h30, 7'h46, 7'h78, 7'h06}, 4'b1010};
        vecs[5] = '{16'h0809, 4'b1111, 1'b1, {4'b1111, 4'b1011, 4'b1101, 4'b1110},
                    {7'h7F, 7'h00, 7'h40, 7'h10}, 4'b1000};
        vecs[6] = '{16'h4D5B, 4'b0000, 1'b1, {4'b0111, 4'b1011, 4'b1101, 4'b1110},
                    {7'h19, 7'h21, 7'h12, 7'h03}, 4'b1111};

        // Reset held, then release and first SHOW of digit 0
        repeat (5) step();
        chk("rst an", 16'(bus.an), 16'h000F);
        chk("rst seg", 16'(bus.seg), 16'h007F);
        chk("rst dp", 16'(bus.dp), 16'h0001);
        chk("rst frame_done", 16'(bus.frame_done), 16'h0000);
        rst = 1'b0;
        step();
        chk("post-rst gap an", 16'(bus.an), 16'h000F);
        step();
        chk("post-rst d0 an", 16'(bus.an), 16'h000E);
        chk("post-rst d0 seg", 16'(bus.seg), 16'h0040);

        // Load then one frame: frame_done on the wrapping tick, new data afterwards
        bus.load = 1'b1; bus.value = 16'h12AF; bus.dp_in = 4'b0000;
        step();
        bus.load = 1'b0;
        repeat (3) next_digit();
        bus.tick = 1'b1;
        step();
        bus.tick = 1'b0;
        chk("wrap frame_done", 16'(bus.frame_done), 16'h0001);
        chk("wrap gap an", 16'(bus.an), 16'h000F);
        step();
        chk("frame_done one-shot", 16'(bus.frame_done), 16'h0000);
        step();
        chk("frame2 d0 an", 16'(bus.an), 16'h000E);
        chk("frame2 d0 seg", 16'(bus.seg), 16'h000E);
        next_digit();
        chk("frame2 d1 an", 16'(bus.an), 16'h000D);
        chk("frame2 d1 seg", 16'(bus.seg), 16'h0008);
        repeat (3) next_digit();

        // Table: load, let it commit at the next wrap, then check every digit slot
        for (int i = 0; i < 7; i++) begin
            bus.load = 1'b1; bus.value = vecs[i].value; bus.dp_in = vecs[i].dp_in; bus.lz_blank = vecs[i].lz;
            step();
            bus.load = 1'b0;
            repeat (4) next_digit();
            for (int d = 0; d < 4; d++) begin
                chk($sformatf("vec%0d d%0d an", i, d), 16'(bus.an), 16'(vecs[i].an[d]));
                chk($sformatf("vec%0d d%0d seg", i, d), 16'(bus.seg), 16'(vecs[i].seg[d]));
                chk($sformatf("vec%0d d%0d dp", i, d), 16'(bus.dp), 16'(vecs[i].dp[d]));
                next_digit();
            end
        end

        // Mid-frame load: rest of this frame keeps 4D5B, 1111 appears after the wrap
        next_digit();
        bus.load = 1'b1; bus.value = 16'h1111; bus.dp_in = 4'b0000; bus.lz_blank = 1'b0;
        step();
        bus.load = 1'b0;
        chk("midload d1 old", 16'(bus.seg), 16'h0012);
        next_digit();
        chk("midload d2 old", 16'(bus.seg), 16'h0021);
        next_digit();
        chk("midload d3 old", 16'(bus.seg), 16'h0019);
        bus.tick = 1'b1;
        step();
        bus.tick = 1'b0;
        chk("midload frame_done", 16'(bus.frame_done), 16'h0001);
        step();
        step();
        chk("midload d0 new", 16'(bus.seg), 16'h0079);

        // Load coincident with the wrapping tick commits immediately
        repeat (3) next_digit();
        bus.load = 1'b1; bus.value = 16'h2222; bus.tick = 1'b1;
        step();
        bus.load = 1'b0; bus.tick = 1'b0;
        step();
        step();
        chk("bypass d0 an", 16'(bus.an), 16'h000E);
        chk("bypass d0 seg", 16'(bus.seg), 16'h0024);

        // Tick during the blank gap is dropped
        bus.tick = 1'b1;
        step();
        step();
        bus.tick = 1'b0;
        chk("blank tick gap an", 16'(bus.an), 16'h000F);
        step();
        chk("blank tick ignored an", 16'(bus.an), 16'h000D);
        chk("blank tick ignored seg", 16'(bus.seg), 16'h0024);

        // Asynchronous reset mid-SHOW, between clock edges
        #3;
        rst = 1'b1;
        #1;
        chk("async rst an", 16'(bus.an), 16'h000F);
        chk("async rst seg", 16'(bus.seg), 16'h007F);
        chk("async rst dp", 16'(bus.dp), 16'h0001);
        rst = 1'b0;
        step();
        chk("restart gap an", 16'(bus.an), 16'h000F);
        chk("nogap d0 an", 16'(bus0.an), 16'h000E);
        step();
        chk("restart d0 an", 16'(bus.an), 16'h000E);
        chk("restart d0 seg", 16'(bus.seg), 16'h0040);

        // Zero-gap build: each tick advances in one edge, back-to-back ticks honoured
        bus0.tick = 1'b1;
        step();
        chk("nogap d1 an", 16'(bus0.an), 16'h000D);
        chk("nogap d1 seg", 16'(bus0.seg), 16'h0040);
        step();
        bus0.tick = 1'b0;
        chk("nogap d2 an", 16'(bus0.an), 16'h000B);
        step();
        chk("nogap hold an", 16'(bus0.an), 16'h000B);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
